// File: rtl/fifo_tg_pkg.sv
// Shared types and constants for the FIFO traffic generator.
package fifo_tg_pkg;

    typedef enum logic [2:0] {
        TG_IDLE,
        TG_FILL,
        TG_MIXED,
        TG_DRAIN,
        TG_DONE
    } tg_state_e;

    localparam int unsigned PCT_SCALE = 100;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Maps a random byte onto 0..PCT_SCALE-1.
    function automatic logic [7:0] pct_draw(input logic [7:0] b);
        return 8'((16'(b) * 16'(PCT_SCALE)) >> 8);
    endfunction

endpackage

// File: rtl/fifo_tg_lfsr.sv
// 16-bit Galois LFSR with advance enable; loads SEED on reset.
module fifo_tg_lfsr
    import fifo_tg_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] lfsr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= SEED;
        end else if (en) begin
            lfsr <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
        end
    end

endmodule

// File: rtl/fifo_traffic_gen.sv
// Weighted-random stimulus master for a synchronous FIFO: fill, mixed traffic, drain.
// Define FIFO_TG_CHECK_EN to enable read-data ordering and error-flag checking.
module fifo_traffic_gen
    import fifo_tg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned WR_PCT     = 70,
    parameter int unsigned RD_PCT     = 30,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  num_txn,
    input  logic                  allow_violate,
    input  logic                  full,
    input  logic                  empty,
    input  logic                  wr_ack,
    input  logic                  overflow,
    input  logic                  underflow,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_in,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  wr_count,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic [CNT_WIDTH-1:0]  err_count
);

    tg_state_e             state_q;
    logic [15:0]           lfsr;
    logic [CNT_WIDTH-1:0]  num_txn_q, fill_cnt_q, mix_cnt_q;
    logic [CNT_WIDTH-1:0]  wr_count_q, rd_count_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  busy_q, done_q;
    logic [7:0]            rw, rr;
    logic                  wr_acc, rd_acc, fill_last, mix_last;

    fifo_tg_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q != TG_IDLE),
        .lfsr (lfsr)
    );

    assign rw = pct_draw(lfsr[15:8]);
    assign rr = pct_draw(lfsr[7:0]);

    always_comb begin
        wr_en = 1'b0;
        rd_en = 1'b0;
        unique case (state_q)
            TG_FILL:  wr_en = !full || allow_violate;
            TG_MIXED: begin
                wr_en = (32'(rw) < WR_PCT) && (!full || allow_violate);
                rd_en = (32'(rr) < RD_PCT) && (!empty || allow_violate);
            end
            // Drain stops reading as soon as the FIFO reports empty.
            TG_DRAIN: rd_en = !empty;
            default: ;
        endcase
    end

    assign wr_acc    = wr_en && !full;
    assign rd_acc    = rd_en && !empty;
    assign fill_last = (fill_cnt_q == CNT_WIDTH'(FIFO_DEPTH - 1));
    // num_txn of zero still spends one cycle in MIXED.
    assign mix_last  = ({1'b0, mix_cnt_q} + 1'b1) >= {1'b0, num_txn_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= TG_IDLE;
            num_txn_q  <= '0;
            fill_cnt_q <= '0;
            mix_cnt_q  <= '0;
            wr_count_q <= '0;
            rd_count_q <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != TG_IDLE) begin
                if (wr_ack && !(&wr_count_q)) wr_count_q <= wr_count_q + 1'b1;
                if (rd_acc && !(&rd_count_q)) rd_count_q <= rd_count_q + 1'b1;
                if (wr_acc)                   data_q     <= data_q + 1'b1;
            end
            case (state_q)
                TG_IDLE: begin
                    if (start) begin
                        num_txn_q  <= num_txn;
                        fill_cnt_q <= '0;
                        mix_cnt_q  <= '0;
                        wr_count_q <= '0;
                        rd_count_q <= '0;
                        data_q     <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= TG_FILL;
                    end
                end
                TG_FILL: begin
                    fill_cnt_q <= fill_cnt_q + 1'b1;
                    if (full || fill_last) state_q <= TG_MIXED;
                end
                TG_MIXED: begin
                    mix_cnt_q <= mix_cnt_q + 1'b1;
                    if (mix_last) state_q <= TG_DRAIN;
                end
                TG_DRAIN: begin
                    if (empty) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= TG_DONE;
                    end
                end
                TG_DONE: state_q <= TG_IDLE;
                default: state_q <= TG_IDLE;
            endcase
        end
    end

    assign data_in  = data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign wr_count = wr_count_q;
    assign rd_count = rd_count_q;

`ifdef FIFO_TG_CHECK_EN
    logic [DATA_WIDTH-1:0] exp_q, exp_hold_q;
    logic                  rd_pend_q;
    logic [CNT_WIDTH-1:0]  err_q;
    logic                  mismatch, flag_err;
    logic [CNT_WIDTH:0]    err_sum;

    assign mismatch = rd_pend_q && (data_out != exp_hold_q);
    assign flag_err = (overflow || underflow) && !allow_violate && (state_q != TG_IDLE);
    assign err_sum  = {1'b0, err_q} + (CNT_WIDTH + 1)'(mismatch) + (CNT_WIDTH + 1)'(flag_err);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q      <= '0;
            exp_hold_q <= '0;
            rd_pend_q  <= 1'b0;
            err_q      <= '0;
        end else begin
            rd_pend_q <= rd_acc;
            if (rd_acc) begin
                exp_hold_q <= exp_q;
                exp_q      <= exp_q + 1'b1;
            end
            if (state_q == TG_IDLE && start) begin
                exp_q <= '0;
                err_q <= '0;
            end else begin
                err_q <= err_sum[CNT_WIDTH] ? '1 : err_sum[CNT_WIDTH-1:0];
            end
        end
    end

    assign err_count = err_q;
`else
    logic unused_chk;
    assign unused_chk = ^{data_out, overflow, underflow};
    assign err_count  = '0;
`endif

endmodule
